id_ex_stage_reg: RTL
====================

Name: id_ex_stage_reg

Overview:
- Pipeline register between decode (register-file read) and execute in the 5-stage RISC-V core.
- Captures decoded control, immediate, PC and both register-file read operands.
- Applies write-back bypass so an operand written in the same cycle is never stale.
- Detects load-use hazards and inserts bubbles; honours external stall and flush from the hazard/branch logic.

Parameters:
- XLEN, 32, data/PC/immediate width
- ALU_OP_W, 4, width of ALU operation code

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- stall  input  1  hold all ID/EX contents this cycle
- flush  input  1  kill the instruction entering EX (branch/jump redirect)
- id_valid  input  1  decode slot holds a real instruction
- id_pc  input  XLEN  PC of decoding instruction
- id_imm  input  XLEN  sign-extended immediate
- id_rs1, id_rs2, id_rd  input  5 each  register addresses
- id_rd1, id_rd2  input  XLEN each  register-file read data for rs1/rs2
- id_reg_write, id_mem_read, id_mem_write, id_alu_src  input  1 each  decoded control
- id_alu_op  input  ALU_OP_W  ALU operation
- wb_reg_write  input  1  write-back stage writing register file this cycle
- wb_rd  input  5  write-back destination
- wb_data  input  XLEN  write-back value
- load_use_stall  output  1  combinational; upstream must hold PC and IF/ID
- ex_valid  output  1  EX slot holds a real instruction
- ex_pc, ex_imm, ex_rs1_data, ex_rs2_data  output  XLEN each  registered copies
- ex_rs1, ex_rs2, ex_rd  output  5 each  registered addresses
- ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src  output  1 each  registered control
- ex_alu_op  output  ALU_OP_W  registered ALU op

Behaviour:
- Reset: while rst is high, every registered output is 0 immediately, independent of clk. This includes ex_valid and all control, data and address outputs.
- Latency: one cycle. Values present at posedge N appear on ex_* after posedge N.
- load_use_stall = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)). Purely combinational; not gated by stall.
- Per-edge priority: flush > stall > load_use_stall > capture.
  - flush: ex_valid <= 0; ex_reg_write, ex_mem_read, ex_mem_write <= 0. Other fields are don't-care; they are driven to 0.
  - stall (no flush): all fields hold, except the held-operand refresh below.
  - load_use_stall (no flush, no stall): insert a bubble, with the same effect as flush. The decode instruction is retried next cycle because upstream holds.
  - capture: load all id_* into ex_*. ex_valid <= id_valid. When id_valid = 0, the three write/memory control bits load as 0.
- Bypass on capture: if wb_reg_write & (wb_rd != 0) & (wb_rd == id_rs1), then ex_rs1_data <= wb_data, else id_rd1. rs2 is handled identically and independently.
- Held-operand refresh: during stall with ex_valid = 1, if wb_reg_write & (wb_rd != 0) & (wb_rd == ex_rs1), ex_rs1_data <= wb_data. rs2 is handled identically.
- Register x0: an address of 0 never matches for bypass, refresh or hazard detection.
- rst asserted mid-stall or mid-bubble: state clears to 0. After release, the first edge performs a normal capture.

Optional Feature:
- Macro PIPE_PERF_COUNTERS_EN.
- Defined:
  - Adds outputs bubble_count and flush_count, each 32 bits.
  - bubble_count increments on every load_use bubble edge. flush_count increments on every flush edge.
  - Both wrap at 2^32 and reset to 0 on rst.
  - stall-only edges count neither.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Plain capture: id_valid=1, id_pc=0x100, id_rd1=0xAAAA0000, id_rs1=3, no hazards -> after one edge ex_valid=1, ex_pc=0x100, ex_rs1_data=0xAAAA0000.
- WB bypass and x0:
  - id_rs1=5, id_rd1=0x1, wb_reg_write=1, wb_rd=5, wb_data=0xDEADBEEF -> ex_rs1_data=0xDEADBEEF.
  - Same stimulus with rs1=wb_rd=0 -> ex_rs1_data=id_rd1.
- Load-use:
  - Stage 1: EX holds lw with ex_rd=7. Decode id_rs2=7 -> load_use_stall=1 same cycle.
  - Stage 2: after the edge, ex_valid=0 and ex_mem_read=0 (bubble).
  - Stage 3: on the next edge the retried instruction is captured with ex_valid=1.
- Stall + refresh: ex_valid=1, ex_rs1=9, stall=1, wb writes x9=0x55 -> fields held; ex_rs1_data=0x55.
- Flush vs stall: flush=1 and stall=1 together -> ex_valid=0, ex_reg_write=0. With PIPE_PERF_COUNTERS_EN defined, flush_count increments by 1.
- Async reset: assert rst between edges while ex_valid=1 -> all outputs 0 before the next posedge; first edge after release captures normally.

Source files
------------

// File: rtl/id_ex_stage_reg_if.sv
// id_ex_stage_reg_if: decode/write-back inputs and EX-side outputs of the ID/EX register.
interface id_ex_stage_reg_if #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4
);
  logic                stall, flush, id_valid;
  logic [XLEN-1:0]     id_pc, id_imm, id_rd1, id_rd2;
  logic [4:0]          id_rs1, id_rs2, id_rd;
  logic                id_reg_write, id_mem_read, id_mem_write, id_alu_src;
  logic [ALU_OP_W-1:0] id_alu_op;
  logic                wb_reg_write;
  logic [4:0]          wb_rd;
  logic [XLEN-1:0]     wb_data;
  logic                load_use_stall, ex_valid;
  logic [XLEN-1:0]     ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
  logic [4:0]          ex_rs1, ex_rs2, ex_rd;
  logic                ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src;
  logic [ALU_OP_W-1:0] ex_alu_op;
  modport master (
    output stall, flush, id_valid, id_pc, id_imm, id_rd1, id_rd2, id_rs1, id_rs2, id_rd,
           id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_alu_op,
           wb_reg_write, wb_rd, wb_data,
    input  load_use_stall, ex_valid, ex_pc, ex_imm, ex_rs1_data, ex_rs2_data, ex_rs1, ex_rs2,
           ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_alu_op
  );
  modport slave (
    input  stall, flush, id_valid, id_pc, id_imm, id_rd1, id_rd2, id_rs1, id_rs2, id_rd,
           id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_alu_op,
           wb_reg_write, wb_rd, wb_data,
    output load_use_stall, ex_valid, ex_pc, ex_imm, ex_rs1_data, ex_rs2_data, ex_rs1, ex_rs2,
           ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_alu_op
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with WB bypass, load-use bubbles, stall and flush.
// Optional PIPE_PERF_COUNTERS_EN adds bubble_count and flush_count outputs.
module id_ex_stage_reg #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
`ifdef PIPE_PERF_COUNTERS_EN
  output logic [31:0]        bubble_count,
  output logic [31:0]        flush_count,
`endif
  id_ex_stage_reg_if.slave   b
);
  typedef struct packed {
    logic                valid;
    logic [XLEN-1:0]     pc, imm, rs1_data, rs2_data;
    logic [4:0]          rs1, rs2, rd;
    logic                reg_write, mem_read, mem_write, alu_src;
    logic [ALU_OP_W-1:0] alu_op;
  } ex_t;
  ex_t  ex_q, ex_d;
  logic load_use, bubble;
  logic wb_hit_id1, wb_hit_id2, wb_hit_ex1, wb_hit_ex2;
  // x0 is never a real destination, so it never bypasses or creates a hazard
  assign wb_hit_id1 = b.wb_reg_write && b.wb_rd != 5'd0 && b.wb_rd == b.id_rs1;
  assign wb_hit_id2 = b.wb_reg_write && b.wb_rd != 5'd0 && b.wb_rd == b.id_rs2;
  assign wb_hit_ex1 = b.wb_reg_write && b.wb_rd != 5'd0 && b.wb_rd == ex_q.rs1;
  assign wb_hit_ex2 = b.wb_reg_write && b.wb_rd != 5'd0 && b.wb_rd == ex_q.rs2;
  assign load_use = b.id_valid && ex_q.valid && ex_q.mem_read && ex_q.rd != 5'd0 &&
                    (ex_q.rd == b.id_rs1 || ex_q.rd == b.id_rs2);
  assign bubble = !b.flush && !b.stall && load_use;
  always_comb begin
    ex_d = ex_q;
    if (b.flush || bubble) begin
      ex_d = '0;
    end else if (b.stall) begin
      ex_d.rs1_data = (ex_q.valid && wb_hit_ex1) ? b.wb_data : ex_q.rs1_data;
      ex_d.rs2_data = (ex_q.valid && wb_hit_ex2) ? b.wb_data : ex_q.rs2_data;
    end else begin
      ex_d.valid     = b.id_valid;
      ex_d.pc        = b.id_pc;
      ex_d.imm       = b.id_imm;
      ex_d.rs1_data  = wb_hit_id1 ? b.wb_data : b.id_rd1;
      ex_d.rs2_data  = wb_hit_id2 ? b.wb_data : b.id_rd2;
      ex_d.rs1       = b.id_rs1;
      ex_d.rs2       = b.id_rs2;
      ex_d.rd        = b.id_rd;
      ex_d.reg_write = b.id_valid && b.id_reg_write;
      ex_d.mem_read  = b.id_valid && b.id_mem_read;
      ex_d.mem_write = b.id_valid && b.id_mem_write;
      ex_d.alu_src   = b.id_alu_src;
      ex_d.alu_op    = b.id_alu_op;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
`ifdef PIPE_PERF_COUNTERS_EN
  logic [31:0] bubble_count_q, bubble_count_d, flush_count_q, flush_count_d;
  always_comb begin
    bubble_count_d = bubble ? bubble_count_q + 32'd1 : bubble_count_q;
    flush_count_d  = b.flush ? flush_count_q + 32'd1 : flush_count_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bubble_count_q <= '0;
      flush_count_q  <= '0;
    end else begin
      bubble_count_q <= bubble_count_d;
      flush_count_q  <= flush_count_d;
    end
  assign bubble_count = bubble_count_q;
  assign flush_count  = flush_count_q;
`endif
  assign b.load_use_stall = load_use;
  assign b.ex_valid       = ex_q.valid;
  assign b.ex_pc          = ex_q.pc;
  assign b.ex_imm         = ex_q.imm;
  assign b.ex_rs1_data    = ex_q.rs1_data;
  assign b.ex_rs2_data    = ex_q.rs2_data;
  assign b.ex_rs1         = ex_q.rs1;
  assign b.ex_rs2         = ex_q.rs2;
  assign b.ex_rd          = ex_q.rd;
  assign b.ex_reg_write   = ex_q.reg_write;
  assign b.ex_mem_read    = ex_q.mem_read;
  assign b.ex_mem_write   = ex_q.mem_write;
  assign b.ex_alu_src     = ex_q.alu_src;
  assign b.ex_alu_op      = ex_q.alu_op;
endmodule
